// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keyboard peripheral:
//   - CPU register indices, decoded from cpu_addr_in[3:2]
//   - STATUS bit positions and CTRL clear-bit positions
//   - receiver state encoding
//   - the frame acceptance rule (odd parity over data+parity, stop bit high)
package ps2_pkg;

  localparam logic [1:0] KBD_STATUS = 2'd0;
  localparam logic [1:0] KBD_DATA   = 2'd1;
  localparam logic [1:0] KBD_CTRL   = 2'd2;

  localparam int STATUS_NONEMPTY_BIT  = 0;
  localparam int STATUS_OVERFLOW_BIT  = 1;
  localparam int STATUS_FRAME_ERR_BIT = 2;
  localparam int STATUS_COUNT_LSB     = 8;

  localparam int CTRL_CLR_OVERFLOW_BIT  = 1;
  localparam int CTRL_CLR_FRAME_ERR_BIT = 2;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // A frame is good when the stop bit is high and data plus parity carry an
  // odd number of ones.
  function automatic logic frame_ok(input logic [7:0] data,
                                    input logic       parity,
                                    input logic       stop_bit);
    return stop_bit & (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx
// PS/2 device-to-host frame receiver.
// Synchronises the raw PS/2 clock and data pins, detects falling edges of the
// PS/2 clock and shifts in one bit per edge: start, 8 data bits LSB first,
// odd parity, stop. A mid-frame stall longer than TIMEOUT_CYCLES aborts the
// frame.
// Ports:
//   clk_in      system clock
//   rst_in      asynchronous active-high reset
//   ps2_clk_in  raw PS/2 clock pin
//   ps2_data_in raw PS/2 data pin
//   byte_valid  one-cycle pulse, byte_data holds a correctly framed byte
//   byte_data   last received byte
//   err         one-cycle pulse on a bad parity/stop bit or a timeout
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       err
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   sample;

  rx_state_t       state, state_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic [7:0]      shift_reg, shift_nxt;
  logic            parity_bit, parity_nxt;
  logic [TO_W-1:0] idle_cnt, idle_cnt_nxt;
  logic            byte_valid_nxt;
  logic [7:0]      byte_data_nxt;
  logic            err_nxt;

  // Synchronizer chains reset to 1 because an idle PS/2 bus floats high;
  // clk_prev holds the previous synchronised clock for edge detection.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign sample = data_sync[SYNC_STAGES-1];

  // Receiver state and result registers; outputs are registered so the byte
  // and error pulses appear in the cycle after the stop-bit edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_idx    <= bit_idx_nxt;
      shift_reg  <= shift_nxt;
      parity_bit <= parity_nxt;
      idle_cnt   <= idle_cnt_nxt;
      byte_valid <= byte_valid_nxt;
      byte_data  <= byte_data_nxt;
      err        <= err_nxt;
    end
  end

  // Next-state logic. The stall counter defaults to zero, so it clears on any
  // edge, while idle, and when a timeout abort fires.
  always_comb begin
    state_nxt      = state;
    bit_idx_nxt    = bit_idx;
    shift_nxt      = shift_reg;
    parity_nxt     = parity_bit;
    idle_cnt_nxt   = '0;
    byte_valid_nxt = 1'b0;
    byte_data_nxt  = byte_data;
    err_nxt        = 1'b0;

    if (fall) begin
      case (state)
        IDLE: begin
          // A high sample here is a glitch, not a start bit.
          if (!sample) begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
          end
        end
        DATA: begin
          // LSB arrives first, so shift in from the top.
          shift_nxt   = {sample, shift_reg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = PARITY;
          end
        end
        PARITY: begin
          parity_nxt = sample;
          state_nxt  = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (frame_ok(shift_reg, parity_bit, sample)) begin
            byte_valid_nxt = 1'b1;
            byte_data_nxt  = shift_reg;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (idle_cnt == TO_LAST) begin
        state_nxt = IDLE;
        err_nxt   = 1'b1;
      end else begin
        idle_cnt_nxt = idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard
// Memory-mapped PS/2 keyboard peripheral. Received scan-code bytes are queued
// in a circular FIFO and exposed to the CPU through three registers:
//   0 STATUS (RO): bit0 nonempty, bit1 overflow, bit2 frame_err, [15:8] count
//   1 DATA   (RO): head byte, 0 when empty; reading does not pop
//   2 CTRL   (WO): any write pops one entry; data bit1/bit2 clear the
//                  overflow/frame_err sticky bits
// Ports:
//   clk_in              system clock (clk_50mhz)
//   rst_in              asynchronous active-high reset
//   ps2_clk_in          raw PS/2 clock pin
//   ps2_data_in         raw PS/2 data pin
//   cpu_addr_in         bus byte address, bits [3:2] select the register
//   cpu_data_in         bus write data
//   cpu_write_enable_in byte write enables, any bit set means write
//   cpu_data_out        registered read data, one cycle after the address
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  input  logic [31:0] cpu_addr_in,
  input  logic [31:0] cpu_data_in,
  input  logic [3:0]  cpu_write_enable_in,
  output logic [31:0] cpu_data_out
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_err;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             frame_err;

  logic [1:0]  reg_sel;
  logic        bus_write;
  logic        ctrl_write;
  logic        fifo_empty;
  logic        fifo_full;
  logic        do_pop;
  logic        do_push;
  logic        overflow_event;
  logic [31:0] status_word;
  logic [31:0] read_word;

  // Only the register index and the two CTRL clear bits are decoded.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{cpu_addr_in[31:4], cpu_addr_in[1:0],
                             cpu_data_in[31:3], cpu_data_in[0]};

  ps2_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .byte_valid (rx_valid),
    .byte_data  (rx_byte),
    .err        (rx_err)
  );

  assign reg_sel    = cpu_addr_in[3:2];
  assign bus_write  = |cpu_write_enable_in;
  assign ctrl_write = bus_write && (reg_sel == KBD_CTRL);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // only an overflow when nothing is leaving.
  assign do_pop         = ctrl_write && !fifo_empty;
  assign do_push        = rx_valid && (!fifo_full || do_pop);
  assign overflow_event = rx_valid && fifo_full && !do_pop;

  // FIFO storage and pointers; the power-of-two depth lets the pointers wrap
  // by plain overflow.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        fifo_mem[wr_ptr] <= rx_byte;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Sticky error bits; a new event in the same cycle as a clear wins.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overflow_event) begin
        overflow <= 1'b1;
      end else if (ctrl_write && cpu_data_in[CTRL_CLR_OVERFLOW_BIT]) begin
        overflow <= 1'b0;
      end
      if (rx_err) begin
        frame_err <= 1'b1;
      end else if (ctrl_write && cpu_data_in[CTRL_CLR_FRAME_ERR_BIT]) begin
        frame_err <= 1'b0;
      end
    end
  end

  // Read mux over the current (pre-update) register values.
  always_comb begin
    status_word                               = '0;
    status_word[STATUS_NONEMPTY_BIT]          = !fifo_empty;
    status_word[STATUS_OVERFLOW_BIT]          = overflow;
    status_word[STATUS_FRAME_ERR_BIT]         = frame_err;
    status_word[STATUS_COUNT_LSB +: 8]        = 8'(count);

    read_word = '0;
    case (reg_sel)
      KBD_STATUS: read_word = status_word;
      KBD_DATA: begin
        if (!fifo_empty) begin
          read_word = {24'h0, fifo_mem[rd_ptr]};
        end
      end
      default: read_word = '0;
    endcase
  end

  // Registered read port: one cycle of latency.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cpu_data_out <= '0;
    end else begin
      cpu_data_out <= read_word;
    end
  end

endmodule
